// File: rtl/key_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, per-key stability counter FSM,
// registered active-high level with one-cycle press/release strobes.
module key_debounce #(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n_in,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_UP     = 2'd0,
    ST_UP_CHK = 2'd1,
    ST_DOWN   = 2'd2,
    ST_DN_CHK = 2'd3
  } state_e;

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = key_n_in;
    sync2_d = sync1_q;
  end

  // Synchroniser resets to "released" so a held key is seen as a fresh press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             down_q, down_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             s;

    assign s = sync2_q[i];

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      down_d    = down_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        ST_UP: begin
          down_d = 1'b0;
          if (!s) begin
            state_d = ST_UP_CHK;
            cnt_d   = '0;
          end
        end
        ST_UP_CHK: begin
          if (s) begin
            state_d = ST_UP;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_DOWN;
            cnt_d   = '0;
            down_d  = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DOWN: begin
          down_d = 1'b1;
          if (s) begin
            state_d = ST_DN_CHK;
            cnt_d   = '0;
          end
        end
        ST_DN_CHK: begin
          if (!s) begin
            state_d = ST_DOWN;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = ST_UP;
            cnt_d     = '0;
            down_d    = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_UP;
          cnt_d   = '0;
          down_d  = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= ST_UP;
        cnt_q     <= '0;
        down_q    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        down_q    <= down_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign key_down[i]    = down_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DEBOUNCE_CYCLES=4: per-cycle vector table fed
// through an expected-value queue, plus a hand sequence for reset mid-check.
module tb_key_debounce;

  localparam int unsigned NK = 2;
  localparam int unsigned DB = 4;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_n_in;
  logic [NK-1:0] key_down;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  key_debounce #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n_in    (key_n_in),
    .key_down    (key_down),
    .key_press   (key_press),
    .key_release (key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] key_n;
    logic [1:0] down;
    logic [1:0] press;
    logic [1:0] rel;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   row    = 0;

  function automatic void add(input logic [1:0] kn, input logic [1:0] dn,
                              input logic [1:0] pr, input logic [1:0] rl);
    vec_t v;
    v.key_n = kn; v.down = dn; v.press = pr; v.rel = rl;
    tbl.push_back(v);
  endfunction

  function automatic void add_run(input int n, input logic [1:0] kn, input logic [1:0] dn);
    for (int k = 0; k < n; k++) add(kn, dn, 2'b00, 2'b00);
  endfunction

  task automatic check_out(input string name, input logic [1:0] dn,
                           input logic [1:0] pr, input logic [1:0] rl);
    checks++;
    if (key_down !== dn || key_press !== pr || key_release !== rl) begin
      errors++;
      $display("FAIL %s row %0d: got down=%b press=%b rel=%b, want down=%b press=%b rel=%b",
               name, row, key_down, key_press, key_release, dn, pr, rl);
    end
  endtask

  // Drive at negedge, expected result queued, compared 1 time unit after posedge
  task automatic run_table(input string name);
    vec_t v, e;
    row = 0;
    while (tbl.size() > 0) begin
      v = tbl.pop_front();
      @(negedge clk);
      key_n_in = v.key_n;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_out(name, e.down, e.press, e.rel);
      row++;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    key_n_in = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    row = 0;
    check_out("reset_values", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;

    // Idle after reset: nothing happens
    add_run(20, 2'b11, 2'b00);
    run_table("idle");

    // Clean press on key 0: accepted at edge D+2
    add_run(6, 2'b10, 2'b00);
    add(2'b10, 2'b01, 2'b01, 2'b00);
    add(2'b10, 2'b01, 2'b00, 2'b00);
    run_table("press0");

    add_run(6, 2'b11, 2'b01);
    add(2'b11, 2'b00, 2'b00, 2'b01);
    add(2'b11, 2'b00, 2'b00, 2'b00);
    run_table("release0");

    // Bounce 0,0,1,0...: press lands 6 edges after the last reversal
    add(2'b10, 2'b00, 2'b00, 2'b00);
    add(2'b10, 2'b00, 2'b00, 2'b00);
    add(2'b11, 2'b00, 2'b00, 2'b00);
    add_run(6, 2'b10, 2'b00);
    add(2'b10, 2'b01, 2'b01, 2'b00);
    add(2'b10, 2'b01, 2'b00, 2'b00);
    add_run(6, 2'b11, 2'b01);
    add(2'b11, 2'b00, 2'b00, 2'b01);
    add(2'b11, 2'b00, 2'b00, 2'b00);
    run_table("bounce0");

    // Both keys together
    add_run(6, 2'b00, 2'b00);
    add(2'b00, 2'b11, 2'b11, 2'b00);
    add(2'b00, 2'b11, 2'b00, 2'b00);
    add_run(6, 2'b11, 2'b11);
    add(2'b11, 2'b00, 2'b00, 2'b11);
    add(2'b11, 2'b00, 2'b00, 2'b00);
    run_table("both");

    // Key 1 steady while key 0 bounces once
    add(2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01, 2'b00, 2'b00, 2'b00);
    add_run(4, 2'b00, 2'b00);
    add(2'b00, 2'b10, 2'b10, 2'b00);
    add(2'b00, 2'b10, 2'b00, 2'b00);
    add(2'b00, 2'b11, 2'b01, 2'b00);
    add(2'b00, 2'b11, 2'b00, 2'b00);
    add_run(6, 2'b11, 2'b11);
    add(2'b11, 2'b00, 2'b00, 2'b11);
    add(2'b11, 2'b00, 2'b00, 2'b00);
    run_table("indep");

    // Key 1 down, key 0 in UP_CHK with cnt=2, then reset
    add_run(6, 2'b01, 2'b00);
    add(2'b01, 2'b10, 2'b10, 2'b00);
    add(2'b01, 2'b10, 2'b00, 2'b00);
    add_run(5, 2'b00, 2'b10);
    run_table("pre_reset");

    #1;
    rst_n = 1'b0;
    #1;
    row = 0;
    check_out("reset_async", 2'b00, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      row = k + 1;
      check_out("reset_hold", 2'b00, 2'b00, 2'b00);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Both keys still held: reported as fresh presses 6 edges later
    add_run(6, 2'b00, 2'b00);
    add(2'b00, 2'b11, 2'b11, 2'b00);
    add(2'b00, 2'b11, 2'b00, 2'b00);
    run_table("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
